// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and helpers for the Nios II OCI trace-capture monitor.
package nios2_oci_trace_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } trace_state_e;

   function automatic int entry_width(input int buf_width, input int count_width);
      return buf_width + count_width;
   endfunction

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
      logic [63:0] all_ones;
      all_ones = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
      if (value >= all_ones) begin
         return all_ones;
      end else begin
         return value + 64'd1;
      end
   endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// Show-ahead synchronous FIFO with extra-bit pointers; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module nios2_oci_trace_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop_ready,
   output logic                     push_accepted,
   output logic                     valid,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             pop_s;

   assign empty         = (wr_ptr_r == rd_ptr_r);
   assign full          = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign level         = wr_ptr_r - rd_ptr_r;
   assign pop_s         = pop_ready && !empty;
   assign push_accepted = push && (!full || pop_s);
   assign valid         = !empty;
   assign head_data     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

   // Read/write pointer advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_accepted) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_accepted) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/nios2_oci_trace_monitor.sv
// Trace-capture monitor: samples the OCI DCT buffer on frame completion,
// queues frames for a drain port and handles end-of-test flush/abort.
module nios2_oci_trace_monitor
   import nios2_oci_trace_pkg::*;
#(
   parameter int BUF_WIDTH   = 30,
   parameter int COUNT_WIDTH = 4,
   parameter int FRAME_COUNT = 15,
   parameter int DEPTH       = 16,
   parameter int STAT_WIDTH  = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [BUF_WIDTH-1:0]               dct_buffer,
   input  logic [COUNT_WIDTH-1:0]             dct_count,
   input  logic                               test_ending,
   input  logic                               test_has_ended,
   output logic                               out_valid,
   output logic [COUNT_WIDTH+BUF_WIDTH-1:0]   out_data,
   input  logic                               out_ready,
   output logic [$clog2(DEPTH):0]             level,
   output logic [STAT_WIDTH-1:0]              frame_count,
   output logic [STAT_WIDTH-1:0]              drop_count,
   output logic                               overflow,
   output logic                               done,
   output logic                               aborted
);

   localparam int EW = entry_width(BUF_WIDTH, COUNT_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] FRAME_VAL = COUNT_WIDTH'(FRAME_COUNT);

   trace_state_e            state_r;
   trace_state_e            state_next_s;
   logic [COUNT_WIDTH-1:0]  prev_count_r;
   logic [STAT_WIDTH-1:0]   frame_count_r;
   logic [STAT_WIDTH-1:0]   drop_count_r;
   logic                    overflow_r;
   logic                    done_r;
   logic                    aborted_r;
   logic                    strobe_s;
   logic                    push_s;
   logic                    set_abort_s;
   logic                    push_accepted_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [EW-1:0]           push_entry_s;

   assign strobe_s     = (state_r == ST_RUN) && (dct_count == FRAME_VAL) &&
                         (prev_count_r != FRAME_VAL);
   assign push_entry_s = {dct_count, dct_buffer};

   nios2_oci_trace_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (push_s),
      .push_data     (push_entry_s),
      .pop_ready     (out_ready),
      .push_accepted (push_accepted_s),
      .valid         (out_valid),
      .head_data     (out_data),
      .level         (level),
      .full          (fifo_full_s),
      .empty         (fifo_empty_s)
   );

   // Next-state, capture and abort decisions; abort outranks flush.
   always_comb begin
      state_next_s = state_r;
      push_s       = 1'b0;
      set_abort_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (test_has_ended) begin
               state_next_s = ST_DONE;
               set_abort_s  = 1'b1;
            end else if (test_ending) begin
               state_next_s = ST_FLUSH;
               push_s       = strobe_s ||
                              ((dct_count != {COUNT_WIDTH{1'b0}}) && (dct_count != FRAME_VAL));
            end else begin
               push_s = strobe_s;
            end
         end
         ST_FLUSH: begin
            if (test_has_ended) begin
               state_next_s = ST_DONE;
               set_abort_s  = 1'b1;
            end else if (fifo_empty_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_FLUSH;
            end
         end
         ST_DONE: begin
            state_next_s = ST_DONE;
         end
         default: begin
            state_next_s = ST_RUN;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Count history, saturating statistics and sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_count_r  <= {COUNT_WIDTH{1'b0}};
         frame_count_r <= {STAT_WIDTH{1'b0}};
         drop_count_r  <= {STAT_WIDTH{1'b0}};
         overflow_r    <= 1'b0;
         done_r        <= 1'b0;
         aborted_r     <= 1'b0;
      end else begin
         prev_count_r <= dct_count;
         done_r       <= (state_next_s == ST_DONE);
         if (push_s && push_accepted_s) begin
            frame_count_r <= STAT_WIDTH'(sat_inc(64'(frame_count_r), STAT_WIDTH));
         end
         if (push_s && !push_accepted_s) begin
            drop_count_r <= STAT_WIDTH'(sat_inc(64'(drop_count_r), STAT_WIDTH));
            overflow_r   <= 1'b1;
         end
         if (set_abort_s) begin
            aborted_r <= 1'b1;
         end
      end
   end

   assign frame_count = frame_count_r;
   assign drop_count  = drop_count_r;
   assign overflow    = overflow_r;
   assign done        = done_r;
   assign aborted     = aborted_r;

endmodule

// File: tb/tb_nios2_oci_trace_monitor.sv
// Randomised and directed bench for nios2_oci_trace_monitor against a
// queue-based reference model.
module tb_nios2_oci_trace_monitor;

   localparam int BW    = 30;
   localparam int CW    = 4;
   localparam int FC    = 15;
   localparam int DEPTH = 16;
   localparam int SW    = 5;
   localparam int EW    = BW + CW;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int SMAX  = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [BW-1:0] dct_buffer;
   logic [CW-1:0] dct_count;
   logic          test_ending;
   logic          test_has_ended;
   logic          out_valid;
   logic [EW-1:0] out_data;
   logic          out_ready;
   logic [LW-1:0] level;
   logic [SW-1:0] frame_count;
   logic [SW-1:0] drop_count;
   logic          overflow;
   logic          done;
   logic          aborted;

   always #5 clk = ~clk;

   nios2_oci_trace_monitor #(
      .BUF_WIDTH   (BW),
      .COUNT_WIDTH (CW),
      .FRAME_COUNT (FC),
      .DEPTH       (DEPTH),
      .STAT_WIDTH  (SW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .level          (level),
      .frame_count    (frame_count),
      .drop_count     (drop_count),
      .overflow       (overflow),
      .done           (done),
      .aborted        (aborted)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: 0 = running, 1 = flushing, 2 = finished.
   logic [EW-1:0] mq[$];
   int            m_state;
   int            m_prev;
   int            m_fc;
   int            m_dc;
   bit            m_ovf;
   bit            m_abort;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = 0;
      m_prev  = 0;
      m_fc    = 0;
      m_dc    = 0;
      m_ovf   = 1'b0;
      m_abort = 1'b0;
   endtask

   task automatic model_step(input int cnt, input logic [BW-1:0] b, input bit ending,
                             input bit ended, input bit ready);
      int  size0;
      bit  pop;
      bit  strobe;
      bit  want_push;
      size0     = mq.size();
      pop       = ready && (size0 > 0);
      strobe    = (m_state == 0) && (cnt == FC) && (m_prev != FC);
      want_push = 1'b0;
      if (m_state == 0) begin
         if (ended) begin
            m_state = 2;
            m_abort = 1'b1;
         end else if (ending) begin
            m_state   = 1;
            want_push = strobe || (cnt != 0 && cnt != FC);
         end else begin
            want_push = strobe;
         end
      end else if (m_state == 1) begin
         if (ended) begin
            m_state = 2;
            m_abort = 1'b1;
         end else if (size0 == 0) begin
            m_state = 2;
         end
      end
      if (pop) begin
         void'(mq.pop_front());
      end
      if (want_push) begin
         if (size0 < DEPTH || pop) begin
            mq.push_back({cnt[CW-1:0], b});
            if (m_fc < SMAX) m_fc++;
         end else begin
            if (m_dc < SMAX) m_dc++;
            m_ovf = 1'b1;
         end
      end
      m_prev = cnt;
   endtask

   task automatic compare_all();
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("level", level, mq.size());
      chk("frame_count", frame_count, m_fc);
      chk("drop_count", drop_count, m_dc);
      chk("overflow", overflow, m_ovf);
      chk("done", done, m_state == 2);
      chk("aborted", aborted, m_abort);
   endtask

   // One clock cycle: drive at negedge, advance model, check at next negedge.
   task automatic cyc(input int cnt, input logic [BW-1:0] b, input bit ending,
                      input bit ended, input bit ready, input bit rst);
      reset          = rst;
      dct_count      = cnt[CW-1:0];
      dct_buffer     = b;
      test_ending    = ending;
      test_has_ended = ended;
      out_ready      = ready;
      if (rst) model_reset();
      else     model_step(cnt, b, ending, ended, ready);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic frame(input logic [BW-1:0] b, input bit ready);
      cyc(0, b, 1'b0, 1'b0, ready, 1'b0);
      cyc(FC, b, 1'b0, 1'b0, ready, 1'b0);
   endtask

   task automatic do_reset();
      cyc(0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [BW-1:0] pat;
      logic [EW-1:0] exp_entry;
      pat            = 30'h2AAAAAAA;
      exp_entry      = {4'hF, pat};
      reset          = 1'b1;
      dct_count      = '0;
      dct_buffer     = '0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      out_ready      = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      chk("reset_out_data", out_data, 64'd0);

      // Counting 0..15 yields exactly one frame; holding at 15 adds nothing.
      for (int i = 0; i < 16; i++) cyc(i, pat, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_level", level, 64'd1);
      chk("t1_entry", out_data, exp_entry);
      chk("t1_frames", frame_count, 64'd1);
      for (int i = 0; i < 5; i++) cyc(FC, pat, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_hold_level", level, 64'd1);

      // 17 frames into a 16-deep FIFO with no consumer.
      do_reset();
      for (int i = 0; i < 17; i++) frame(BW'($urandom), 1'b0);
      chk("t2_level", level, 64'd16);
      chk("t2_drops", drop_count, 64'd1);
      chk("t2_ovf", overflow, 64'd1);
      // Same, but the 17th push coincides with a pop.
      do_reset();
      for (int i = 0; i < 16; i++) frame(BW'($urandom), 1'b0);
      cyc(0, pat, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(FC, pat, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2b_drops", drop_count, 64'd0);
      chk("t2b_level", level, 64'd16);

      // Partial frame on flush request, then drain to completion.
      do_reset();
      frame(BW'($urandom), 1'b0);
      frame(BW'($urandom), 1'b0);
      cyc(7, pat, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_level", level, 64'd3);
      chk("t3_done_early", done, 64'd0);
      for (int i = 0; i < 2; i++) cyc(0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_partial_head", out_data, {4'h7, pat});
      cyc(0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_done_at_pop", done, 64'd0);
      cyc(0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_done", done, 64'd1);
      chk("t3_aborted", aborted, 64'd0);

      // Abort with three entries queued and a strobe in the same cycle.
      do_reset();
      for (int i = 0; i < 3; i++) frame(BW'($urandom), 1'b0);
      cyc(0, pat, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(FC, pat, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_done", done, 64'd1);
      chk("t4_aborted", aborted, 64'd1);
      chk("t4_frames", frame_count, 64'd3);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_drained", level, 64'd0);

      // Asynchronous reset in the middle of a flush.
      do_reset();
      for (int i = 0; i < 5; i++) frame(BW'($urandom), 1'b0);
      cyc(0, pat, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_level", level, 64'd5);
      reset = 1'b1;
      #1;
      chk("t5_async_valid", out_valid, 64'd0);
      chk("t5_async_data", out_data, 64'd0);
      chk("t5_async_level", level, 64'd0);
      chk("t5_async_frames", frame_count, 64'd0);
      chk("t5_async_done", done, 64'd0);
      model_reset();
      @(negedge clk);
      do_reset();
      frame(pat, 1'b0);
      chk("t5_run_again", level, 64'd1);

      // Frame counter saturation.
      do_reset();
      for (int i = 0; i < SMAX + 2; i++) frame(BW'($urandom), 1'b1);
      chk("t6_sat", frame_count, 64'(SMAX));
      chk("t6_drops", drop_count, 64'd0);

      // Randomised traffic with occasional flush, abort and reset.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         int cnt;
         bit rdy;
         bit rst;
         cnt = ($urandom_range(0, 2) == 0) ? FC : int'($urandom_range(0, 15));
         rdy = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0) || (m_state == 2 && $urandom_range(0, 19) == 0);
         cyc(cnt, BW'($urandom), $urandom_range(0, 149) == 0, $urandom_range(0, 599) == 0,
             rdy, rst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nios2_oci_trace_monitor.md
# nios2_oci_trace_monitor

Parametrised trace-capture monitor for the Nios II OCI debug trace path (DCT buffer/count). Samples the packed trace buffer whenever the trace counter completes a frame, queues frames in an internal FIFO for a simulation or debug drain port, and handles end-of-test flush and abort. Sits beside the CPU's OCI block in test and debug builds; it has no effect on CPU behaviour.

## Interface
Parameters:
- BUF_WIDTH, 30, width of dct_buffer.
- COUNT_WIDTH, 4, width of dct_count.
- FRAME_COUNT, 15, dct_count value that marks a complete frame; must be nonzero and fit COUNT_WIDTH.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- dct_buffer  in  BUF_WIDTH  packed trace data.
- dct_count  in  COUNT_WIDTH  valid-slot count in dct_buffer.
- test_ending  in  1  level; requests a graceful flush.
- test_has_ended  in  1  level; immediate abort.
- out_valid  out  1  FIFO head valid.
- out_data  out  COUNT_WIDTH+BUF_WIDTH  {count, buffer} of the head entry.
- out_ready  in  1  consumer accepts the head.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- frame_count  out  STAT_WIDTH  frames pushed; saturating.
- drop_count  out  STAT_WIDTH  frames dropped because the FIFO was full; saturating.
- overflow  out  1  sticky; set on the first drop.
- done  out  1  high in DONE.
- aborted  out  1  sticky; DONE was reached through test_has_ended.

## Operation
- States: RUN, FLUSH, DONE. Reset puts the block in RUN.
- Register prev_count holds the sampled dct_count. Capture strobe = (dct_count == FRAME_COUNT) && (prev_count != FRAME_COUNT). The strobe is valid in RUN only.
- Push entry = {dct_count, dct_buffer}, sampled at the strobe edge.
- RUN to FLUSH: test_ending = 1 and test_has_ended = 0. On the transition cycle, a partial frame is pushed if dct_count is neither 0 nor FRAME_COUNT. A full frame with a strobe in the same cycle is pushed as a normal frame.
- FLUSH to DONE: the FIFO is empty. No new captures occur in FLUSH.
- Any state to DONE: test_has_ended = 1. This takes priority over test_ending. Any capture in that cycle is discarded without counting. aborted is set unless the block is already in DONE.
- DONE is terminal until reset. The drain port keeps working in DONE.
- Push when full: the entry is dropped, drop_count increments, and overflow is set. Exception: if a pop happens in the same cycle (out_valid && out_ready), the push is accepted.
- Pop happens when out_valid && out_ready. out_data is show-ahead: the head is presented while out_valid = 1.
- Counters saturate at all-ones and never wrap.
- Reset values: out_valid 0, out_data 0, level 0, frame_count 0, drop_count 0, overflow 0, done 0, aborted 0, prev_count 0. Reset mid-operation discards all FIFO contents.

## Timing
- A push at clock edge N gives out_valid = 1 after edge N, with out_data equal to that entry. Push-to-visible latency is 1 cycle.
- A pop at edge N presents the next entry, or drops out_valid, after edge N.
- level, frame_count and drop_count update at the same edge as the push or pop.
- done rises at the edge where the state enters DONE. In FLUSH, that is the edge following the pop that empties the FIFO, so it is observable one cycle after the pop.
- All outputs are registered. There is no combinational path from inputs to outputs except out_valid/out_data, which come from registers only.

## Structure
- Package nios2_oci_trace_pkg holds:
  - the state enum (RUN, FLUSH, DONE);
  - a function for entry width;
  - a saturating-increment function.
- Sub-module nios2_oci_trace_fifo: synchronous, show-ahead FIFO parametrised by width and DEPTH, using extra-bit read/write pointers. It provides full, empty, level and push-while-full-with-pop acceptance.
- The top level holds the capture strobe, the FSM and the statistics.

## Test plan
- Step dct_count 0..15 with dct_buffer = 0x2AAAAAAA, out_ready = 0 → one entry {0xF, 0x2AAAAAAA}; frame_count = 1. Holding count at 15 for 5 cycles adds nothing.
- 17 frames with out_ready = 0 and DEPTH = 16 → level = 16, drop_count = 1, overflow = 1. Repeat with out_ready = 1 on the 17th push cycle → drop_count = 0.
- dct_count = 7 and test_ending = 1 → partial entry {0x7, buf} pushed, state FLUSH. Drain everything → done = 1 one cycle after the last pop; aborted = 0.
- test_has_ended = 1 with 3 entries queued and a strobe in the same cycle → done = 1, aborted = 1, frame_count unchanged, 3 entries still drainable.
- reset asserted mid-FLUSH with 5 entries → all outputs 0 asynchronously; after release the block is in RUN with level = 0.
- frame_count at STAT_WIDTH all-ones plus 2 more frames → value stays all-ones.
